plot_framebuffer_reader: RTL
============================

Name: plot_framebuffer_reader

Overview:
Terminating end of the pixel-plot interface (x, y, colour, plot) that drawscreen-style drawing engines drive. Captures every plotted pixel into an on-chip 320x240 framebuffer. Streams the stored image back out in raster order over a valid/ready port, for self-checking benches, screenshot dump and a future scan-out path. Also provides a hardware clear sweep to the background colour.

Parameters:
WIDTH, 320, visible columns
HEIGHT, 240, visible rows
CW, 3, colour bits per pixel
BG_COLOUR, 3'b000, value written by clear sweep

Ports:
CLOCK_50  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
vga_x  in  9  plot column
vga_y  in  8  plot row
vga_colour  in  CW  plot colour
vga_plot  in  1  write strobe, one pixel per cycle when high
clear  in  1  pulse: start clear sweep
clear_busy  out  1  high while sweep in progress
rd_start  in  1  pulse: start raster readout
rd_busy  out  1  high from rd_start accept until last beat transferred
rd_valid  out  1  readout beat valid
rd_ready  in  1  consumer accepts beat
rd_x  out  9  column of current beat
rd_y  out  8  row of current beat
rd_colour  out  CW  stored colour
rd_last  out  1  high on beat (WIDTH-1, HEIGHT-1)
drop_count  out  16  plots rejected (out of range or during clear), saturating

Behaviour:
- Reset values: clear_busy 0, rd_busy 0, rd_valid 0, rd_x 0, rd_y 0, rd_colour 0, rd_last 0, drop_count 0. RAM contents not reset.
- Address = y*WIDTH + x, 17 bits. Multiplication done as (y<<8)+(y<<6)+x for WIDTH=320; general WIDTH uses a constant multiply.
- Write path: vga_plot=1, x<WIDTH, y<HEIGHT, clear_busy=0 -> RAM write on that edge. Otherwise strobe dropped and drop_count+1, saturating at 16'hFFFF. No write buffering; back-to-back plots every cycle are supported.
- Clear FSM states are C_IDLE and C_SWEEP.
  - clear in C_IDLE -> C_SWEEP at address 0. Writes BG_COLOUR, one address per cycle, for WIDTH*HEIGHT cycles (76800), then returns to C_IDLE.
  - clear_busy = (state==C_SWEEP).
  - clear while already in C_SWEEP is ignored.
- Read FSM states are R_IDLE, R_FETCH and R_STREAM.
  - rd_start in R_IDLE -> R_FETCH, rd_busy=1. rd_start is ignored while rd_busy=1.
  - The RAM read port has 1-cycle latency. Prefetch into a 2-entry skid FIFO so rd_valid sustains one beat per cycle while rd_ready=1.
  - While rd_valid=1 and rd_ready=0, rd_x, rd_y, rd_colour and rd_last hold stable.
  - The FIFO must never overflow: issue a read only if occupancy plus in-flight reads is less than 2.
  - Read counter: x increments; at x=WIDTH-1 it wraps to 0 and y increments.
  - rd_last asserts exactly on the final beat. Transfer of that beat -> R_IDLE and rd_busy=0 on the next cycle.
- Read-during-write to the same address on the same edge returns OLD data. The stream reflects RAM state at each fetch cycle. Concurrent plots are allowed.
- rd_start and clear on the same cycle: both are accepted. The readout is not coherent with the sweep; benches must not rely on it.
- Async reset mid-sweep or mid-readout: both FSMs go idle immediately, the FIFO empties and partially cleared RAM is left as is.

Decomposition:
- Package fb_pkg holds SCREEN_W/SCREEN_H, ADDR_W=17, colour constants (BLACK 3'b000, RED 3'b100, MAGENTA 3'b101, WHITE 3'b111) and the clear/read FSM state enums.
- Sub-module fb_ram is a simple dual-port RAM (1 write port, 1 registered read port, old-data-on-collision), inferable as M10K.

Test Plan:
1. Reset, clear, wait for clear_busy=0, then readout with rd_ready=1 -> 76800 beats, all colour 0, rd_last only on (319,239), rd_busy low the following cycle.
2. Plot (10,91)=3'b111 and (315,228)=3'b101 after the clear, then readout -> beat index 29130 has colour 7, beat index 73275 has colour 5, all others 0.
3. Plot (320,0) and (0,240) -> drop_count=2, no RAM change (verified by readout).
4. Readout with rd_ready toggling 1,0,0,1 pseudo-randomly -> no beat lost or duplicated, outputs stable while stalled, beat sequence identical to the rd_ready=1 run.
5. Plot (0,0)=3'b100 during clear_busy -> drop_count increments, pixel reads BG_COLOUR after the sweep.
6. rst_n low at readout beat 1000 -> rd_valid/rd_busy 0 immediately; a new rd_start restarts from (0,0).

Source files
------------

// File: rtl/fb_pkg.sv
// Shared screen geometry, colour constants, FSM state types and the
// shift-add pixel address helper for the plot framebuffer.
package fb_pkg;

  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;
  localparam int ADDR_W   = 17;

  localparam logic [2:0] BLACK   = 3'b000;
  localparam logic [2:0] RED     = 3'b100;
  localparam logic [2:0] MAGENTA = 3'b101;
  localparam logic [2:0] WHITE   = 3'b111;

  typedef enum logic {
    C_IDLE  = 1'b0,
    C_SWEEP = 1'b1
  } clr_state_e;

  typedef enum logic [1:0] {
    R_IDLE   = 2'b00,
    R_FETCH  = 2'b01,
    R_STREAM = 2'b10
  } rd_state_e;

  // y*320 + x without a multiplier: y*256 + y*64 + x
  function automatic logic [ADDR_W-1:0] addr_320(input logic [8:0] x, input logic [7:0] y);
    logic [ADDR_W-1:0] yy;
    yy = {9'd0, y};
    return (yy << 4'd8) + (yy << 4'd6) + {8'd0, x};
  endfunction

endpackage

// File: rtl/fb_ram.sv
// Simple dual-port pixel RAM: one write port, one registered read port.
// A read and write to the same address on one edge returns the old data.
module fb_ram #(
  parameter int DEPTH = 76800,
  parameter int AW    = 17,
  parameter int DW    = 3
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam int IW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  // Storage write and registered read; no reset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr[IW-1:0]] <= wdata;
    end
    rdata_q <= mem_q[raddr[IW-1:0]];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/plot_framebuffer_reader.sv
// Captures plotted pixels into a framebuffer, sweeps it to the background
// colour on request and streams it back out in raster order (valid/ready).
module plot_framebuffer_reader
  import fb_pkg::*;
#(
  parameter int            WIDTH     = SCREEN_W,
  parameter int            HEIGHT    = SCREEN_H,
  parameter int            CW        = 3,
  parameter logic [CW-1:0] BG_COLOUR = {CW{1'b0}}
) (
  input  logic          CLOCK_50,
  input  logic          rst_n,
  input  logic [8:0]    vga_x,
  input  logic [7:0]    vga_y,
  input  logic [CW-1:0] vga_colour,
  input  logic          vga_plot,
  input  logic          clear,
  output logic          clear_busy,
  input  logic          rd_start,
  output logic          rd_busy,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [8:0]    rd_x,
  output logic [7:0]    rd_y,
  output logic [CW-1:0] rd_colour,
  output logic          rd_last,
  output logic [15:0]   drop_count
);

  localparam int                NPIX      = WIDTH * HEIGHT;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
  localparam logic [ADDR_W-1:0] W_A       = ADDR_W'(WIDTH);
  localparam logic [8:0]        X_LIM     = 9'(WIDTH);
  localparam logic [8:0]        Y_LIM     = 9'(HEIGHT);
  localparam logic [8:0]        X_MAX     = 9'(WIDTH - 1);

  clr_state_e        clr_state_q, clr_state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  rd_state_e         rd_state_q, rd_state_d;
  logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
  logic [8:0]        fetch_x_q, fetch_x_d;
  logic [7:0]        fetch_y_q, fetch_y_d;
  logic              inflight_q, inflight_d;
  logic [8:0]        tag_x_q, tag_x_d;
  logic [7:0]        tag_y_q, tag_y_d;
  logic              tag_last_q, tag_last_d;
  logic [8:0]        head_x_q, head_x_d, tail_x_q, tail_x_d;
  logic [7:0]        head_y_q, head_y_d, tail_y_q, tail_y_d;
  logic [CW-1:0]     head_c_q, head_c_d, tail_c_q, tail_c_d;
  logic              head_l_q, head_l_d, tail_l_q, tail_l_d;
  logic [1:0]        count_q, count_d;
  logic [15:0]       drop_q, drop_d;

  logic [ADDR_W-1:0] plot_addr_s, waddr_s;
  logic [CW-1:0]     wdata_s, ram_rdata_s;
  logic              we_s, plot_ok_s, pop_s, push_s, issue_s;

  if (WIDTH == 320) begin : g_addr320
    assign plot_addr_s = addr_320(vga_x, vga_y);
  end else begin : g_addr_mul
    assign plot_addr_s = ({9'd0, vga_y} * W_A) + {8'd0, vga_x};
  end

  fb_ram #(.DEPTH(NPIX), .AW(ADDR_W), .DW(CW)) u_ram (
    .clk   (CLOCK_50),
    .we    (we_s),
    .waddr (waddr_s),
    .wdata (wdata_s),
    .raddr (fetch_addr_q),
    .rdata (ram_rdata_s)
  );

  assign plot_ok_s = vga_plot && ({1'b0, vga_y} < Y_LIM) && (vga_x < X_LIM)
                     && (clr_state_q == C_IDLE);
  assign pop_s     = (count_q != 2'd0) && rd_ready;
  assign push_s    = inflight_q;
  // Counting this cycle's pop keeps one beat per cycle with only two entries
  assign issue_s   = (rd_state_q == R_FETCH) &&
                     (({1'b0, count_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop_s}));

  // Write port arbitration, clear sweep, drop counter and clear FSM next state
  always_comb begin
    we_s        = 1'b0;
    waddr_s     = {ADDR_W{1'b0}};
    wdata_s     = {CW{1'b0}};
    clr_state_d = clr_state_q;
    clr_addr_d  = clr_addr_q;
    drop_d      = drop_q;
    case (clr_state_q)
      C_IDLE: begin
        if (clear) begin
          clr_state_d = C_SWEEP;
          clr_addr_d  = {ADDR_W{1'b0}};
        end else begin
          clr_state_d = C_IDLE;
        end
      end
      C_SWEEP: begin
        we_s    = 1'b1;
        waddr_s = clr_addr_q;
        wdata_s = BG_COLOUR;
        if (clr_addr_q == LAST_ADDR) begin
          clr_state_d = C_IDLE;
        end else begin
          clr_addr_d = clr_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
      end
      default: clr_state_d = C_IDLE;
    endcase
    if (plot_ok_s) begin
      we_s    = 1'b1;
      waddr_s = plot_addr_s;
      wdata_s = vga_colour;
    end else if (vga_plot && (drop_q != 16'hFFFF)) begin
      drop_d = drop_q + 16'd1;
    end else begin
      drop_d = drop_q;
    end
  end

  // Read FSM, fetch counters, read tag pipeline and two-entry skid FIFO
  always_comb begin
    rd_state_d   = rd_state_q;
    fetch_addr_d = fetch_addr_q;
    fetch_x_d    = fetch_x_q;
    fetch_y_d    = fetch_y_q;
    inflight_d   = issue_s;
    tag_x_d      = tag_x_q;
    tag_y_d      = tag_y_q;
    tag_last_d   = tag_last_q;
    head_x_d = head_x_q; head_y_d = head_y_q; head_c_d = head_c_q; head_l_d = head_l_q;
    tail_x_d = tail_x_q; tail_y_d = tail_y_q; tail_c_d = tail_c_q; tail_l_d = tail_l_q;
    count_d  = count_q;
    case (rd_state_q)
      R_IDLE: begin
        if (rd_start) begin
          rd_state_d   = R_FETCH;
          fetch_addr_d = {ADDR_W{1'b0}};
          fetch_x_d    = 9'd0;
          fetch_y_d    = 8'd0;
        end else begin
          rd_state_d = R_IDLE;
        end
      end
      R_FETCH: begin
        if (issue_s) begin
          tag_x_d    = fetch_x_q;
          tag_y_d    = fetch_y_q;
          tag_last_d = (fetch_addr_q == LAST_ADDR);
          if (fetch_addr_q == LAST_ADDR) begin
            rd_state_d = R_STREAM;
          end else if (fetch_x_q == X_MAX) begin
            fetch_addr_d = fetch_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            fetch_x_d    = 9'd0;
            fetch_y_d    = fetch_y_q + 8'd1;
          end else begin
            fetch_addr_d = fetch_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            fetch_x_d    = fetch_x_q + 9'd1;
          end
        end else begin
          rd_state_d = R_FETCH;
        end
      end
      R_STREAM: begin
        if (pop_s && head_l_q) begin
          rd_state_d = R_IDLE;
        end else begin
          rd_state_d = R_STREAM;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
    case ({push_s, pop_s})
      2'b10: begin
        if (count_q == 2'd0) begin
          head_x_d = tag_x_q; head_y_d = tag_y_q; head_c_d = ram_rdata_s; head_l_d = tag_last_q;
          count_d  = 2'd1;
        end else begin
          tail_x_d = tag_x_q; tail_y_d = tag_y_q; tail_c_d = ram_rdata_s; tail_l_d = tag_last_q;
          count_d  = 2'd2;
        end
      end
      2'b01: begin
        if (count_q == 2'd2) begin
          head_x_d = tail_x_q; head_y_d = tail_y_q; head_c_d = tail_c_q; head_l_d = tail_l_q;
          count_d  = 2'd1;
        end else begin
          count_d  = 2'd0;
        end
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          head_x_d = tag_x_q; head_y_d = tag_y_q; head_c_d = ram_rdata_s; head_l_d = tag_last_q;
        end else begin
          head_x_d = tail_x_q; head_y_d = tail_y_q; head_c_d = tail_c_q; head_l_d = tail_l_q;
          tail_x_d = tag_x_q; tail_y_d = tag_y_q; tail_c_d = ram_rdata_s; tail_l_d = tag_last_q;
        end
      end
      default: count_d = count_q;
    endcase
  end

  // State update for both FSMs, FIFO and counters
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      clr_state_q  <= C_IDLE;
      clr_addr_q   <= {ADDR_W{1'b0}};
      rd_state_q   <= R_IDLE;
      fetch_addr_q <= {ADDR_W{1'b0}};
      fetch_x_q    <= 9'd0;
      fetch_y_q    <= 8'd0;
      inflight_q   <= 1'b0;
      tag_x_q      <= 9'd0;
      tag_y_q      <= 8'd0;
      tag_last_q   <= 1'b0;
      head_x_q <= 9'd0; head_y_q <= 8'd0; head_c_q <= {CW{1'b0}}; head_l_q <= 1'b0;
      tail_x_q <= 9'd0; tail_y_q <= 8'd0; tail_c_q <= {CW{1'b0}}; tail_l_q <= 1'b0;
      count_q      <= 2'd0;
      drop_q       <= 16'd0;
    end else begin
      clr_state_q  <= clr_state_d;
      clr_addr_q   <= clr_addr_d;
      rd_state_q   <= rd_state_d;
      fetch_addr_q <= fetch_addr_d;
      fetch_x_q    <= fetch_x_d;
      fetch_y_q    <= fetch_y_d;
      inflight_q   <= inflight_d;
      tag_x_q      <= tag_x_d;
      tag_y_q      <= tag_y_d;
      tag_last_q   <= tag_last_d;
      head_x_q <= head_x_d; head_y_q <= head_y_d; head_c_q <= head_c_d; head_l_q <= head_l_d;
      tail_x_q <= tail_x_d; tail_y_q <= tail_y_d; tail_c_q <= tail_c_d; tail_l_q <= tail_l_d;
      count_q      <= count_d;
      drop_q       <= drop_d;
    end
  end

  assign clear_busy = (clr_state_q == C_SWEEP);
  assign rd_busy    = (rd_state_q != R_IDLE);
  assign rd_valid   = (count_q != 2'd0);
  assign rd_x       = head_x_q;
  assign rd_y       = head_y_q;
  assign rd_colour  = head_c_q;
  assign rd_last    = head_l_q;
  assign drop_count = drop_q;

endmodule
